// File: rtl/cyber_war_pkg.sv
// Shared tug-of-war types: FSM states, LFSR geometry and seed.
// Used by cyber_player and the game core.
package cyber_war_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PRESS,
    COOLDOWN
  } state_e;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  localparam logic [LFSR_W-1:0] LFSR_SEED = '0;

  // XNOR feedback keeps all-zeros legal; all-ones is the lock-up state
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] v
  );
    return {v[LFSR_W-2:0], ~(v[TAP_HI] ^ v[TAP_LO])};
  endfunction

endpackage

// File: rtl/cyber_player_if.sv
// Game-side bundle between the difficulty switches, the
// automated player and the right-player input of the core.
interface cyber_player_if;
  logic       enable;
  logic [8:0] difficulty;
  logic       press;
  logic       key_n;
  logic       busy;

  modport master (
    output enable,
    output difficulty,
    input  press,
    input  key_n,
    input  busy
  );

  modport slave (
    input  enable,
    input  difficulty,
    output press,
    output key_n,
    output busy
  );
endinterface

// File: rtl/lfsr10.sv
// 10-bit XNOR LFSR with synchronous active-low reset and
// an advance strobe; shared with the game core.
module lfsr10
  import cyber_war_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr_next(value_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) value_q <= LFSR_SEED;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/cyber_player.sv
// Automated tug-of-war opponent driving an emulated key.
// CYBER_LFSR_FREERUN_EN: LFSR advances every clock.
module cyber_player
  import cyber_war_pkg::*;
#(
  parameter int TICK_DIV   = 1,
  parameter int HOLD_TICKS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  cyber_player_if.slave  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COOL_INIT = CW'(HOLD_TICKS - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [CW-1:0]     cool_q, cool_d;
  logic              press_q, press_d;
  logic              key_n, busy;
  logic              tick, press_req, advance;
  logic [LFSR_W-1:0] lfsr;

  assign tick      = (tick_q == TICK_LAST);
  assign press_req = ({1'b0, bus.difficulty} > lfsr);

`ifdef CYBER_LFSR_FREERUN_EN
  assign advance = 1'b1;
`else
  assign advance = bus.enable && tick && (state_q != IDLE);
`endif

  lfsr10 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (advance),
    .value   (lfsr)
  );

  always_comb begin
    tick_d = '0;
    if (bus.enable && !tick) tick_d = tick_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      cool_q  <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cool_q  <= cool_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    if (!bus.enable) begin
      state_d = IDLE;
      cool_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (tick && press_req) state_d = PRESS;
        end
        PRESS: begin
          if (tick) begin
            state_d = COOLDOWN;
            cool_d  = COOL_INIT;
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cool_q == '0) state_d = ARMED;
            else cool_d = cool_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // press is registered so it marks only the entry into PRESS
  always_comb begin
    press_d = bus.enable && tick && press_req
              && (state_q == ARMED);
    key_n   = (state_q != PRESS);
    busy    = (state_q == PRESS) || (state_q == COOLDOWN);
  end

  assign bus.press = press_q;
  assign bus.key_n = key_n;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_cyber_player.sv
// Randomised bench for cyber_player against a timeline model.
// Scenario pins plus a per-cycle compare process.
module tb_cyber_player;
  import cyber_war_pkg::*;

  localparam int HOLD = 1;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  cyber_player_if bus ();

  cyber_player #(
    .TICK_DIV   (1),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Timeline model: the player is described by the cycle of its
  // last press and the first cycle it may decide again.
  function automatic logic [9:0] m_step(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  int         t      = 0;
  bit         m_act  = 1'b0;
  int         m_next = 1 << 30;
  int         m_pat  = -100;
  logic [9:0] m_lfsr = '0;

  always @(posedge clk) begin
    t = t + 1;
    if (!reset_n) begin
      m_act  = 1'b0;
      m_lfsr = '0;
      m_next = 1 << 30;
      m_pat  = -100;
    end else if (!bus.enable) begin
      m_act  = 1'b0;
      m_next = 1 << 30;
      m_pat  = -100;
    end else if (!m_act) begin
      m_act  = 1'b1;
      m_next = t;
    end else begin
      if (t - 1 >= m_next &&
          {1'b0, bus.difficulty} > m_lfsr) begin
        m_pat  = t;
        m_next = t + 1 + HOLD;
      end
      m_lfsr = m_step(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("press", bus.press, (m_pat == t));
      check("key_n", bus.key_n, !(m_pat == t));
      check("busy", bus.busy, (t >= m_pat && t <= m_pat + HOLD));
      check("lfsr", dut.lfsr, m_lfsr);
    end
  end

  function automatic bit exp_pat(input int j);
    return (j == 1 || j == 4 || j == 7 || j == 10);
  endfunction

  task automatic restart(input logic [8:0] d);
    reset_n = 1'b0;
    bus.difficulty = d;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_pattern(input string name);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check(name, bus.press, exp_pat(j));
    end
  endtask

  int         cnt;
  bit         found;
  logic [9:0] held;

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b1;
    bus.difficulty = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;

    check("pin_next0", m_step(10'h000), 10'h001);
    check("pin_next7", m_step(10'h007), 10'h00F);
    check("pin_next7F", m_step(10'h07F), 10'h0FE);
    check("rst_keyn", bus.key_n, 1'b1);
    check("rst_lfsr", dut.lfsr, 10'h000);

    // difficulty 0 never presses
    reset_n = 1'b1;
    cnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.press || !bus.key_n || bus.busy) cnt++;
    end
    check("diff0_quiet", cnt, 0);

    // maximum difficulty, press pattern after release
    restart(9'h1FF);
    run_pattern("diff1ff_pat");

    // difficulty 2: only the very first decision wins
    restart(9'h002);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.press) cnt++;
    end
    check("diff2_one", cnt, 1);

    // enable drop during PRESS
    restart(9'h1FF);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.press) found = 1'b1;
    end
    check("press_seen", found, 1'b1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("drop_keyn", bus.key_n, 1'b1);
    check("drop_busy", bus.busy, 1'b0);
    check("drop_idle", dut.state_q == IDLE, 1'b1);
    held = m_lfsr;
    repeat (5) @(negedge clk);
    check("lfsr_hold", dut.lfsr, held);
    bus.enable = 1'b1;
    @(negedge clk);
    check("rearm_nopress", bus.press, 1'b0);
    repeat (10) @(negedge clk);

    // reset mid-COOLDOWN
    restart(9'h1FF);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.busy && bus.key_n) found = 1'b1;
    end
    check("cool_seen", found, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_press", bus.press, 1'b0);
    check("rst_key", bus.key_n, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_lfsr0", dut.lfsr, 10'h000);
    reset_n = 1'b1;
    run_pattern("repeat_pat");

    // randomised play
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) != 0)
          bus.difficulty = 9'($urandom_range(0, 511));
        else
          bus.difficulty = 9'($urandom_range(0, 15));
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
